// File: rtl/led_step_counter.sv
// LED bank counter with configurable width/modulus, prescaled stepping,
// up/down/ping-pong/hold modes, synchronous load and a registered wrap pulse.
module led_step_counter #(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] led_count,
  output logic             dir,
  output logic             wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_COUNT);
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE-1);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [0:0] DIR_UP    = 1'b0;
  localparam logic [0:0] DIR_DN    = 1'b1;

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero;

  assign at_max  = (count_q == MAXV);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_value > MAXV) ? MAXV : load_value;
      pre_d   = '0;
      dir_d   = DIR_UP;
    end else if (!en) begin
      pre_d = pre_q;
    end else if (mode == 2'b11) begin
      pre_d = '0;
    end else if (pre_q != PLAST) begin
      pre_d = pre_q + 1'b1;
    end else begin
      pre_d = '0;
      case (mode)
        MODE_UP: begin
          dir_d = DIR_UP;
          if (at_max) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        MODE_DOWN: begin
          dir_d = DIR_DN;
          if (at_zero) begin
            count_d = MAXV;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        MODE_PP: begin
          // A single-value range has no room to move: reverse in place.
          if (MAXV == '0) begin
            dir_d  = ~dir_q;
            wrap_d = 1'b1;
          end else if (dir_q == DIR_UP) begin
            if (at_max) begin
              count_d = count_q - 1'b1;
              dir_d   = DIR_DN;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end else begin
            if (at_zero) begin
              count_d = count_q + 1'b1;
              dir_d   = DIR_UP;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q - 1'b1;
            end
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      pre_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  assign led_count = count_q;
  assign dir       = dir_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/led_step_counter.md
Name: led_step_counter

Overview:
Parametrised successor to the team's 3-bit LED counter. Drives an LED bank with a counter of configurable width and modulus, advanced by an internal prescaler. Supports up-wrap, down-wrap, ping-pong and hold modes, plus synchronous load. Sits between the board clock/reset and the LED output pins. It also emits a one-cycle wrap pulse for chaining or for other display logic.

Parameters:
WIDTH, 3, counter/LED width in bits (>=1)
MAX_COUNT, 2**WIDTH-1, highest count value; counter range is 0..MAX_COUNT (must be <= 2**WIDTH-1)
PRESCALE, 1, enabled clk cycles per count step (>=1); 1 = step on every enabled cycle

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  reset, asynchronous, active-low
en  input  1  enable; 0 freezes prescaler, count and dir
mode  input  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 hold
load  input  1  synchronous load strobe
load_value  input  WIDTH  value to load
led_count  output  WIDTH  current count, registered
dir  output  1  current direction, 0 = up, 1 = down, registered
wrap  output  1  one-cycle pulse on a wrap/reversal step, registered

Behaviour:
- Reset (reset_n=0, asynchronous): led_count=0, prescaler=0, dir=0, wrap=0. All state holds at these values until reset_n deasserts; the first update is on the next rising clk.
- Priority per cycle: load > en=0 > mode=11 > step.
- load=1 (regardless of en/mode):
  - led_count <= min(load_value, MAX_COUNT).
  - prescaler <= 0, dir <= 0, wrap <= 0.
- en=0, no load: all state holds; wrap <= 0.
- mode=11, en=1, no load: led_count and dir hold; prescaler <= 0; wrap <= 0.
- Prescaler (en=1, mode!=11, no load):
  - Counts 0..PRESCALE-1.
  - A step occurs in the cycle prescaler==PRESCALE-1; prescaler then returns to 0.
  - With PRESCALE=1 every enabled cycle is a step.
- Step, mode 00:
  - count<MAX_COUNT: count+1.
  - count==MAX_COUNT: count <= 0, wrap <= 1.
  - dir <= 0.
- Step, mode 01:
  - count>0: count-1.
  - count==0: count <= MAX_COUNT, wrap <= 1.
  - dir <= 1.
- Step, mode 10 (two-state FSM UP/DOWN held in dir):
  - UP, count<MAX_COUNT: count+1.
  - UP, count==MAX_COUNT: count-1, dir <= DOWN, wrap <= 1.
  - DOWN, count>0: count-1.
  - DOWN, count==0: count+1, dir <= UP, wrap <= 1.
  - Endpoints are never repeated on consecutive steps.
- MAX_COUNT=0: count stays 0 in every mode. Every step pulses wrap; in mode 10 dir still toggles.
- Non-step cycles: wrap <= 0. wrap is high for exactly one cycle after each qualifying step.
- Mode change mid-operation: takes effect at the next step. Prescaler phase, count and dir carry over. Entering mode 10 continues in the current dir.
- led_count never exceeds MAX_COUNT; no arithmetic overflow beyond WIDTH bits.
- Outputs change only on clk rising edge or reset assertion; no combinational path from inputs to outputs.

Test Plan:
- Reset: WIDTH=3, MAX_COUNT=7, PRESCALE=1, mode=00, en=1; assert reset_n=0 mid-count at 5 -> led_count=0, dir=0, wrap=0 immediately (no clk edge). After release, sequence 1,2,...,7,0 with wrap=1 only in the cycle count shows 0.
- Prescale and enable: PRESCALE=3, mode=00, en=1 -> count increments every 3rd cycle (0,0,1,1,1,2...). Drop en for 5 cycles mid-phase -> count and phase frozen; resume -> step occurs after the remaining phase cycles.
- Down-wrap: MAX_COUNT=5, mode=01 from 0, PRESCALE=1 -> 5,4,3,2,1,0,5 with dir=1. wrap pulses on the 0->5 step.
- Ping-pong: MAX_COUNT=3, mode=10 from 0 -> 1,2,3,2,1,0,1. dir goes to 1 after reaching 3 and back to 0 after 0; wrap pulses on the 3->2 and 0->1 steps.
- Load: MAX_COUNT=5, load_value=7 with en=0 -> led_count=5, dir=0, prescaler cleared. Load asserted in the same cycle as a step -> loaded value wins, wrap=0.
- Hold and mode switch: counting up at 4 in mode 10, switch to 11 for 4 cycles -> led_count stays 4. Switch to 01 -> next step gives 3, dir=1.
